// File: rtl/div_clk_monitor_if.sv
// Bundles the divided-clock input, control inputs and measurement/status outputs of div_clk_monitor.
interface div_clk_monitor_if #(
  parameter int CNT_W = 8
);
  logic             div_clk_i;
  logic             enable;
  logic             fault_clr;
  logic             rise_o;
  logic             fall_o;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             period_vld;
  logic             locked;
  logic             fault;

  modport master (
    output div_clk_i, enable, fault_clr,
    input  rise_o, fall_o, period_o, high_o, period_vld, locked, fault
  );

  modport slave (
    input  div_clk_i, enable, fault_clr,
    output rise_o, fall_o, period_o, high_o, period_vld, locked, fault
  );
endinterface

// File: rtl/div_clk_monitor.sv
// Samples a divided clock on clk_in, measures period/high time and tracks lock/fault status.
// Define DIV_MON_SYNC_EN to add a two-flop synchronizer when div_clk_i comes from another domain.
module div_clk_monitor #(
  parameter int EXP_RATIO = 10,
  parameter int CNT_W     = 8,
  parameter int LOCK_CNT  = 4
) (
  input  logic                clk_in,
  input  logic                rstn,
  div_clk_monitor_if.slave    mon
);

  localparam int               MATCH_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(2 * EXP_RATIO);
  localparam logic [CNT_W-1:0] LP_EXP  = CNT_W'(EXP_RATIO);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);
  localparam logic [MATCH_W-1:0] LP_LOCK  = MATCH_W'(LOCK_CNT);
  localparam logic [MATCH_W-1:0] LP_MONE  = MATCH_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACQ,
    ST_MEAS,
    ST_LOCKED,
    ST_FAULT
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [MATCH_W-1:0] r_match;
  logic [MATCH_W-1:0] w_match_nxt;
  logic [CNT_W-1:0]   r_per_cnt;
  logic [CNT_W-1:0]   r_hi_cnt;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_high;
  logic               r_s_q;
  logic               r_s_qq;
  logic               r_stall_seen;
  logic               w_div_in;
  logic               w_rise;
  logic               w_fall;
  logic               w_measure;
  logic               w_good;
  logic               w_stall;
  logic               w_clr_cnt;

`ifdef DIV_MON_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= mon.div_clk_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_div_in = r_sync2;
`else
  assign w_div_in = mon.div_clk_i;
`endif

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_s_q  <= 1'b0;
      r_s_qq <= 1'b0;
    end else begin
      r_s_q  <= w_div_in;
      r_s_qq <= r_s_q;
    end
  end

  assign w_rise    = r_s_q & ~r_s_qq;
  assign w_fall    = ~r_s_q & r_s_qq;
  assign w_measure = w_rise && ((r_state == ST_MEAS) || (r_state == ST_LOCKED));
  assign w_good    = (r_per_cnt == LP_EXP) && ({r_hi_cnt, 1'b0} == {1'b0, r_per_cnt});
  // Stall fires once when the period counter saturates; cleared again by the next rise.
  assign w_stall   = !w_rise && (r_per_cnt == LP_MAX) && !r_stall_seen;
  assign w_clr_cnt = (r_state == ST_IDLE) || (w_state_nxt == ST_IDLE) ||
                     ((r_state == ST_FAULT) && (w_state_nxt == ST_ACQ));

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_per_cnt    <= '0;
      r_hi_cnt     <= '0;
      r_stall_seen <= 1'b0;
    end else if (w_clr_cnt) begin
      r_per_cnt    <= '0;
      r_hi_cnt     <= '0;
      r_stall_seen <= 1'b0;
    end else if (w_rise) begin
      r_per_cnt    <= LP_ONE;
      r_hi_cnt     <= LP_ONE;
      r_stall_seen <= 1'b0;
    end else begin
      if (r_per_cnt != LP_MAX) r_per_cnt <= r_per_cnt + LP_ONE;
      if (r_s_q && (r_hi_cnt != LP_MAX)) r_hi_cnt <= r_hi_cnt + LP_ONE;
      if (w_stall) r_stall_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_period <= '0;
      r_high   <= '0;
    end else if (w_state_nxt == ST_IDLE) begin
      r_period <= '0;
      r_high   <= '0;
    end else if (w_measure) begin
      r_period <= r_per_cnt;
      r_high   <= r_hi_cnt;
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_match <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_match <= w_match_nxt;
    end
  end

  // Lock needs LOCK_CNT consecutive good periods; the rise that ends ACQ is never measured.
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    case (r_state)
      ST_IDLE: begin
        w_match_nxt = '0;
        if (mon.enable) w_state_nxt = ST_ACQ;
      end
      ST_ACQ: begin
        w_match_nxt = '0;
        if (w_rise) w_state_nxt = ST_MEAS;
      end
      ST_MEAS: begin
        if (w_rise) begin
          if (w_good) begin
            w_match_nxt = r_match + LP_MONE;
            if ((r_match + LP_MONE) == LP_LOCK) w_state_nxt = ST_LOCKED;
          end else begin
            w_match_nxt = '0;
          end
        end else if (w_stall) begin
          w_match_nxt = '0;
        end
      end
      ST_LOCKED: begin
        if ((w_rise && !w_good) || w_stall) w_state_nxt = ST_FAULT;
      end
      ST_FAULT: begin
        if (mon.fault_clr) begin
          w_state_nxt = ST_ACQ;
          w_match_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_match_nxt = '0;
      end
    endcase
    if (!mon.enable) begin
      w_state_nxt = ST_IDLE;
      w_match_nxt = '0;
    end
  end

  assign mon.rise_o     = w_rise;
  assign mon.fall_o     = w_fall;
  assign mon.period_vld = w_measure;
  assign mon.period_o   = w_measure ? r_per_cnt : r_period;
  assign mon.high_o     = w_measure ? r_hi_cnt : r_high;
  assign mon.locked     = (r_state == ST_LOCKED);
  assign mon.fault      = (r_state == ST_FAULT);

endmodule
